// File: rtl/oob_retry_sched_if.sv
//------------------------------------------------------------------------------
// oob_retry_sched_if
// Control/status bundle between the host control logic / OOB controller
// (master side) and the OOB retry scheduler (slave side).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface oob_retry_sched_if;
    logic        en;
    logic        retry_clr;
    logic        gtx_ready;
    logic        oob_error;
    logic        oob_silence;
    logic        link_up;
    logic        link_down;
    logic        oob_rst;
    logic [3:0]  retry_cnt;
    logic        give_up;
    logic [2:0]  state_dbg;
    logic [15:0] drop_cnt;

    modport master (
        output en, retry_clr, gtx_ready, oob_error, oob_silence, link_up, link_down,
        input  oob_rst, retry_cnt, give_up, state_dbg, drop_cnt
    );

    modport slave (
        input  en, retry_clr, gtx_ready, oob_error, oob_silence, link_up, link_down,
        output oob_rst, retry_cnt, give_up, state_dbg, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/oob_retry_sched.sv
//------------------------------------------------------------------------------
// oob_retry_sched
// Schedules OOB restarts for the SATA host PHY: after each OOB/link failure it
// waits an exponentially growing backoff, then pulses oob_rst; gives up after
// MAX_RETRIES consecutive failures.
// Optional feature macro: OOB_RETRY_STATS_EN (link-drop counter on drop_cnt).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module oob_retry_sched #(
    parameter int CLK_SPEED_GRADE   = 1,
    parameter int MAX_RETRIES       = 8,
    parameter int BASE_BACKOFF      = 1024,
    parameter int BACKOFF_SHIFT_MAX = 4,
    parameter int RST_PULSE         = 8,
    parameter int TIMER_W           = 24
) (
    input  wire logic         clk,
    input  wire logic         rst,
    oob_retry_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_LINKED  = 3'd2,
        S_BACKOFF = 3'd3,
        S_RESTART = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    localparam int PULSE_W = (RST_PULSE < 2) ? 1 : $clog2(RST_PULSE + 1);

    localparam logic [TIMER_W-1:0] c_base_ticks = TIMER_W'(BASE_BACKOFF * CLK_SPEED_GRADE);
    localparam logic [PULSE_W-1:0] c_pulse_len  = PULSE_W'(RST_PULSE);
    localparam logic [3:0]         c_max_cnt    = 4'(MAX_RETRIES);
    localparam logic [4:0]         c_max_cnt5   = 5'(MAX_RETRIES);
    localparam logic [4:0]         c_shift_cap  = 5'(BACKOFF_SHIFT_MAX);

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [PULSE_W-1:0]   r_pulse_cnt;
    logic                 r_oob_rst;
    logic [3:0]           r_retry_cnt;
    logic                 r_give_up;

    logic [3:0]           w_base_cnt;
    logic [4:0]           w_new_cnt;
    logic [4:0]           w_exp;
    logic                 w_exhausted;
    logic [TIMER_W-1:0]   w_backoff;
    logic                 w_run;

    // Next failure count and backoff interval; a same-cycle retry_clr makes
    // the failure count start again from zero.
    always_comb begin
        w_base_cnt  = bus.retry_clr ? 4'd0 : r_retry_cnt;
        w_new_cnt   = {1'b0, w_base_cnt} + 5'd1;
        w_exp       = (w_new_cnt - 5'd1 > c_shift_cap) ? c_shift_cap : (w_new_cnt - 5'd1);
        w_exhausted = (w_new_cnt >= c_max_cnt5);
        w_backoff   = c_base_ticks << w_exp;
        w_run       = bus.en & bus.gtx_ready;
    end

    // Retry state machine with registered outputs; en/gtx_ready loss overrides
    // every state except FAIL, which only en=0 or retry_clr can leave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_pulse_cnt <= '0;
            r_oob_rst   <= 1'b0;
            r_retry_cnt <= 4'd0;
            r_give_up   <= 1'b0;
        end else if (r_state == S_FAIL) begin
            if (!bus.en || bus.retry_clr) begin
                r_state     <= S_IDLE;
                r_retry_cnt <= 4'd0;
                r_give_up   <= 1'b0;
            end
        end else if (!w_run) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_pulse_cnt <= '0;
            r_oob_rst   <= 1'b0;
            if (bus.retry_clr) begin
                r_retry_cnt <= 4'd0;
            end
        end else begin
            if (bus.retry_clr) begin
                r_retry_cnt <= 4'd0;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (bus.oob_error || bus.oob_silence) begin
                        if (w_exhausted) begin
                            r_state     <= S_FAIL;
                            r_retry_cnt <= c_max_cnt;
                            r_give_up   <= 1'b1;
                        end else begin
                            r_state     <= S_BACKOFF;
                            r_retry_cnt <= w_new_cnt[3:0];
                            r_timer     <= w_backoff;
                        end
                    end else if (bus.link_up) begin
                        r_state     <= S_LINKED;
                        r_retry_cnt <= 4'd0;
                    end
                end
                S_LINKED: begin
                    if (bus.link_down) begin
                        if (w_exhausted) begin
                            r_state     <= S_FAIL;
                            r_retry_cnt <= c_max_cnt;
                            r_give_up   <= 1'b1;
                        end else begin
                            r_state     <= S_BACKOFF;
                            r_retry_cnt <= w_new_cnt[3:0];
                            r_timer     <= w_backoff;
                        end
                    end
                end
                S_BACKOFF: begin
                    // Timer value T gives exactly T cycles in BACKOFF.
                    if (r_timer <= TIMER_W'(1)) begin
                        r_state     <= S_RESTART;
                        r_timer     <= '0;
                        r_oob_rst   <= 1'b1;
                        r_pulse_cnt <= c_pulse_len;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                S_RESTART: begin
                    // oob_rst stays high for exactly RST_PULSE cycles.
                    if (r_pulse_cnt <= PULSE_W'(1)) begin
                        r_state     <= bus.gtx_ready ? S_ARMED : S_IDLE;
                        r_oob_rst   <= 1'b0;
                        r_pulse_cnt <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - PULSE_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OOB_RETRY_STATS_EN
    logic [15:0] r_drop_cnt;

    // Counts link drops accepted while linked; saturates, cleared by retry_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 16'h0;
        end else if (bus.retry_clr) begin
            r_drop_cnt <= 16'h0;
        end else if (r_state == S_LINKED && w_run && bus.link_down
                     && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'h1;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = 16'h0;
`endif

    assign bus.oob_rst   = r_oob_rst;
    assign bus.retry_cnt = r_retry_cnt;
    assign bus.give_up   = r_give_up;
    assign bus.state_dbg = r_state;

endmodule

`default_nettype wire

// File: tb/tb_oob_retry_sched.sv
//------------------------------------------------------------------------------
// tb_oob_retry_sched
// Directed bench for oob_retry_sched: a default-parameter instance (A) and a
// fast, low-retry-limit instance (B) share one stimulus set; checks target one
// instance at a time via a selector.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_oob_retry_sched;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_ARMED = 3'd1, ST_LINKED = 3'd2,
                           ST_BACKOFF = 3'd3, ST_RESTART = 3'd4, ST_FAIL = 3'd5;

`ifdef OOB_RETRY_STATS_EN
    localparam int EXP_DROP1 = 1;
    localparam int EXP_DROP3 = 3;
`else
    localparam int EXP_DROP1 = 0;
    localparam int EXP_DROP3 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, retry_clr = 1'b0, gtx_ready = 1'b0;
    logic oob_error = 1'b0, oob_silence = 1'b0, link_up = 1'b0, link_down = 1'b0;
    logic sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    oob_retry_sched_if ifa ();
    oob_retry_sched_if ifb ();

    assign ifa.en = en;          assign ifb.en = en;
    assign ifa.retry_clr = retry_clr;  assign ifb.retry_clr = retry_clr;
    assign ifa.gtx_ready = gtx_ready;  assign ifb.gtx_ready = gtx_ready;
    assign ifa.oob_error = oob_error;  assign ifb.oob_error = oob_error;
    assign ifa.oob_silence = oob_silence; assign ifb.oob_silence = oob_silence;
    assign ifa.link_up = link_up;      assign ifb.link_up = link_up;
    assign ifa.link_down = link_down;  assign ifb.link_down = link_down;

    oob_retry_sched u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    oob_retry_sched #(
        .CLK_SPEED_GRADE   (4),
        .MAX_RETRIES       (4),
        .BASE_BACKOFF      (4),
        .BACKOFF_SHIFT_MAX (1),
        .RST_PULSE         (2),
        .TIMER_W           (24)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Observed outputs of the instance under test.
    logic [2:0]  st;
    logic [3:0]  rc;
    logic        orst, gu;
    logic [15:0] dc;
    assign st   = sel ? ifb.state_dbg : ifa.state_dbg;
    assign rc   = sel ? ifb.retry_cnt : ifa.retry_cnt;
    assign orst = sel ? ifb.oob_rst   : ifa.oob_rst;
    assign gu   = sel ? ifb.give_up   : ifa.give_up;
    assign dc   = sel ? ifb.drop_cnt  : ifa.drop_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse on a selected input, launched from a negedge.
    // 0=oob_error 1=oob_silence 2=link_up 3=link_down 4=retry_clr
    task automatic fire(input int which);
        case (which)
            0: oob_error   = 1'b1;
            1: oob_silence = 1'b1;
            2: link_up     = 1'b1;
            3: link_down   = 1'b1;
            default: retry_clr = 1'b1;
        endcase
        @(negedge clk);
        oob_error = 1'b0; oob_silence = 1'b0; link_up = 1'b0;
        link_down = 1'b0; retry_clr = 1'b0;
    endtask

    // Counts negedges until the observed state equals target (bounded).
    task automatic wait_st(input logic [2:0] target, input int budget, output int n);
        n = 0;
        while (st !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;

        // Reset values
        tick(1);
        chk("rst_state", st, ST_IDLE);
        chk("rst_retry", rc, 0);
        chk("rst_oobrst", orst, 0);
        chk("rst_giveup", gu, 0);
        chk("rst_drop", dc, 0);

        // Instance A: arm and link
        rst = 1'b0; en = 1'b1; gtx_ready = 1'b1;
        tick(1);
        chk("a_armed", st, ST_ARMED);
        fire(2);
        chk("a_linked", st, ST_LINKED);
        chk("a_linked_retry", rc, 0);
        chk("a_linked_oobrst", orst, 0);
        fire(2);
        chk("a_relink_ignored", st, ST_LINKED);

        // First failure: 1024-cycle backoff, 8-cycle restart pulse
        fire(3);
        chk("a_fail1_state", st, ST_BACKOFF);
        chk("a_fail1_retry", rc, 1);
        chk("a_fail1_oobrst", orst, 0);
        chk("a_drop1", dc, EXP_DROP1);
        wait_st(ST_RESTART, 5000, n);
        chk("a_backoff1_len", n, 1024);
        chk("a_restart_oobrst", orst, 1);
        n = 0;
        while (orst === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_pulse_len", n, 8);
        chk("a_rearmed", st, ST_ARMED);

        // Second failure (silence): 2048 cycles
        fire(1);
        chk("a_fail2_retry", rc, 2);
        wait_st(ST_RESTART, 5000, n);
        chk("a_backoff2_len", n, 2048);
        wait_st(ST_ARMED, 100, n);
        chk("a_restart2_len", n, 8);

        // Third failure: 4096 cycles; a second error inside BACKOFF is ignored
        fire(0);
        chk("a_fail3_retry", rc, 3);
        fire(0);
        chk("a_ignored_retry", rc, 3);
        chk("a_ignored_state", st, ST_BACKOFF);
        wait_st(ST_RESTART, 9000, n);
        chk("a_backoff3_len", n, 4095);
        wait_st(ST_ARMED, 100, n);

        // link_up clears the count; gtx_ready loss mid-BACKOFF -> IDLE
        fire(2);
        chk("a_link_clear", rc, 0);
        fire(3);
        chk("a_drop_retry", rc, 1);
        tick(5);
        gtx_ready = 1'b0;
        tick(1);
        chk("a_gtx_idle", st, ST_IDLE);
        chk("a_gtx_oobrst", orst, 0);
        chk("a_gtx_retry_held", rc, 1);
        gtx_ready = 1'b1;
        tick(1);
        chk("a_gtx_rearm", st, ST_ARMED);
        fire(2);
        fire(3);
        chk("a_drop3", dc, EXP_DROP3);
        fire(4);
        chk("a_clr_state", st, ST_BACKOFF);
        chk("a_clr_retry", rc, 0);
        chk("a_clr_drop", dc, 0);

        // en=0 -> IDLE, then error + link_up in the same cycle in ARMED
        en = 1'b0;
        tick(1);
        chk("a_en_idle", st, ST_IDLE);
        en = 1'b1;
        tick(1);
        oob_error = 1'b1; link_up = 1'b1;
        tick(1);
        oob_error = 1'b0; link_up = 1'b0;
        chk("a_err_wins_state", st, ST_BACKOFF);
        chk("a_err_wins_retry", rc, 1);

        // retry_clr together with a failure: counts from zero
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        chk("a_held_retry", rc, 1);
        oob_error = 1'b1; retry_clr = 1'b1;
        tick(1);
        oob_error = 1'b0; retry_clr = 1'b0;
        chk("a_clr_fail_retry", rc, 1);
        chk("a_clr_fail_state", st, ST_BACKOFF);

        // Async reset mid-BACKOFF
        tick(3);
        #2 rst = 1'b1;
        #1;
        chk("a_async_state", st, ST_IDLE);
        chk("a_async_retry", rc, 0);

        // Instance B: grade 4, base 4, shift cap 1, MAX_RETRIES 4, pulse 2
        sel = 1'b1;
        #1;
        chk("b_rst_state", st, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("b_armed", st, ST_ARMED);
        fire(0);
        chk("b_fail1_retry", rc, 1);
        wait_st(ST_RESTART, 500, n);
        chk("b_backoff1_len", n, 16);
        n = 0;
        while (orst === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_pulse_len", n, 2);
        chk("b_rearmed", st, ST_ARMED);
        fire(0);
        chk("b_fail2_retry", rc, 2);
        wait_st(ST_RESTART, 500, n);
        chk("b_backoff2_len", n, 32);
        wait_st(ST_ARMED, 100, n);
        fire(1);
        chk("b_fail3_retry", rc, 3);
        wait_st(ST_RESTART, 500, n);
        chk("b_backoff3_capped", n, 32);
        wait_st(ST_ARMED, 100, n);
        fire(0);
        chk("b_fail_state", st, ST_FAIL);
        chk("b_fail_retry", rc, 4);
        chk("b_fail_giveup", gu, 1);
        chk("b_fail_oobrst", orst, 0);
        gtx_ready = 1'b0;
        tick(1);
        chk("b_fail_holds", st, ST_FAIL);
        gtx_ready = 1'b1;
        fire(4);
        chk("b_clr_state", st, ST_IDLE);
        chk("b_clr_retry", rc, 0);
        chk("b_clr_giveup", gu, 0);
        tick(1);
        chk("b_clr_rearm", st, ST_ARMED);

        // Async reset mid-RESTART drops oob_rst at once
        fire(0);
        wait_st(ST_RESTART, 500, n);
        tick(1);
        chk("b_mid_pulse", orst, 1);
        #2 rst = 1'b1;
        #1;
        chk("b_async_oobrst", orst, 0);
        chk("b_async_state", st, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
